// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider / clock-enable generator.
// Holds the FSM encoding, settle counter sizing and per-channel ratio extraction.
package clk_div_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } fsm_e;

  localparam int unsigned SETTLE_CYCLES_DEF = 1024;
  localparam int unsigned SETTLE_W_DEF      = $clog2(SETTLE_CYCLES_DEF + 1);
  localparam int unsigned RATIO_VEC_MAX     = 256;
  localparam int unsigned RATIO_MAX_W       = 32;

  // Settle counter width; never below 1 so SETTLE_CYCLES of 0 or 1 still elaborates.
  function automatic int unsigned settle_w(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic logic [RATIO_MAX_W-1:0] ratio_of(
    input logic [RATIO_VEC_MAX-1:0] vec,
    input int unsigned              ch,
    input int unsigned              w
  );
    logic [RATIO_VEC_MAX-1:0] sh;
    logic [RATIO_MAX_W-1:0]   mask;
    sh   = vec >> (ch * w);
    mask = (w >= RATIO_MAX_W) ? '1 : ((RATIO_MAX_W'(1) << w) - RATIO_MAX_W'(1));
    return sh[RATIO_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active ratio, staged ratio and registered outputs.
// A staged ratio is adopted only at the end of the current period so no pulse is cut short.
module clk_div_chan #(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load_req,
  input  logic [DIV_W-1:0] new_div,
  output logic             done,
  output logic             clk_out,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic             pending_q, pending_d, out_q, out_d, en_q, en_d;
  logic             multi, last;

  assign multi = (div_q >= DIV_W'(2));
  assign last  = multi && (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    out_d     = out_q;
    en_d      = en_q;
    if (run) begin
      out_d = multi && (cnt_q < (div_q >> 1));
      en_d  = last || (div_q == DIV_W'(1));
      cnt_d = (multi && !last) ? cnt_q + DIV_W'(1) : '0;
      // pending only goes high after the accept cycle, so for D<=1 this is the first drain cycle
      if (pending_q && (!multi || last)) begin
        div_d     = pend_q;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
      if (load_req) begin
        pend_d    = new_div;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      pend_q    <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      en_q      <= en_d;
    end
  end

  assign done    = !pending_q;
  assign clk_out = out_q;
  assign clk_en  = en_q;

endmodule

// File: rtl/clk_div_gen.sv
// Programmable multi-output clock divider / enable generator with post-reset settle window
// and a valid/ready reconfiguration handshake that drains every channel before the next config.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int                       NUM_OUT       = 3,
  parameter int                       DIV_W         = 8,
  parameter int                       SETTLE_CYCLES = 1024,
  parameter logic [NUM_OUT*DIV_W-1:0] DIV_INIT      = {8'd8, 8'd4, 8'd2}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_OUT*DIV_W-1:0] div_cfg,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic                     ready,
  output logic [NUM_OUT-1:0]       clk_out,
  output logic [NUM_OUT-1:0]       clk_en
);

  localparam int SW = settle_w(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? '0 : SW'(SETTLE_CYCLES - 1);

  fsm_e             state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             ready_q, ready_d, cfg_ready_q, cfg_ready_d;
  logic [NUM_OUT-1:0] done;
  logic             load_req, run, all_done;

  assign load_req = (state_q == RUN) && cfg_ready_q && cfg_valid;
  assign run      = (state_q != SETTLE);
  assign all_done = &done;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    ready_d     = ready_q;
    cfg_ready_d = cfg_ready_q;
    case (state_q)
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d     = RUN;
          ready_d     = 1'b1;
          cfg_ready_d = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      RUN: begin
        if (load_req) begin
          state_d     = DRAIN;
          cfg_ready_d = 1'b0;
        end
      end
      DRAIN: begin
        if (all_done) begin
          state_d     = RUN;
          cfg_ready_d = 1'b1;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SETTLE;
      settle_q    <= '0;
      ready_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      ready_q     <= ready_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
    logic [DIV_W-1:0] new_div;
    assign new_div = DIV_W'(ratio_of(RATIO_VEC_MAX'(div_cfg), i, DIV_W));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_INIT[i*DIV_W +: DIV_W])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .load_req (load_req),
      .new_div  (new_div),
      .done     (done[i]),
      .clk_out  (clk_out[i]),
      .clk_en   (clk_en[i])
    );
  end

  assign ready     = ready_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a cycle model queues expected outputs per edge,
// and each scenario task pops and compares them alongside its own targeted checks.
module tb_clk_div_gen;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int SC = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] div_cfg;
  logic           cfg_valid;
  logic           cfg_ready, ready;
  logic [N-1:0]   clk_out, clk_en;

  typedef struct packed {
    logic         rdy;
    logic         crdy;
    logic [N-1:0] co;
    logic [N-1:0] ce;
  } obs_t;

  obs_t obs;
  assign obs = {ready, cfg_ready, clk_out, clk_en};

  obs_t sb_q[$];
  int   vecs = 0;
  int   errs = 0;

  // reference model state
  int       m_state = 0, m_sc = 0;
  bit       m_ready = 0, m_cfgr = 0;
  int       m_div[N], m_ph[N], m_pend[N];
  bit       m_pending[N];
  bit [N-1:0] m_co = '0, m_ce = '0;
  int       init_div[N] = '{2, 4, 8};

  clk_div_gen #(
    .NUM_OUT       (N),
    .DIV_W         (W),
    .SETTLE_CYCLES (SC),
    .DIV_INIT      ({8'd8, 8'd4, 8'd2})
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .div_cfg   (div_cfg),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .ready     (ready),
    .clk_out   (clk_out),
    .clk_en    (clk_en)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the currently driven inputs, queue its prediction, then clock the DUT.
  task automatic tick();
    bit acc, any_pend;
    obs_t e;
    if (rst) begin
      m_state = 0; m_sc = 0; m_ready = 0; m_cfgr = 0; m_co = '0; m_ce = '0;
      for (int c = 0; c < N; c++) begin
        m_div[c] = init_div[c]; m_ph[c] = 0; m_pending[c] = 0; m_pend[c] = 0;
      end
    end else begin
      acc      = (m_state == 1) && m_cfgr && cfg_valid;
      any_pend = 0;
      for (int c = 0; c < N; c++) any_pend |= m_pending[c];
      for (int c = 0; c < N; c++) begin
        int d;
        bit adopt;
        d = m_div[c];
        adopt = m_pending[c] && ((d <= 1) ? (m_state == 2) : (m_ph[c] == d - 1));
        if (m_state == 0) begin
          m_co[c] = 0; m_ce[c] = 0;
        end else begin
          m_co[c] = (d >= 2) && (m_ph[c] < d / 2);
          m_ce[c] = (d == 1) || ((d >= 2) && (m_ph[c] == d - 1));
          m_ph[c] = ((d >= 2) && (m_ph[c] != d - 1)) ? m_ph[c] + 1 : 0;
          if (adopt) begin m_div[c] = m_pend[c]; m_ph[c] = 0; m_pending[c] = 0; end
        end
        if (acc) begin m_pend[c] = int'(div_cfg[c*W +: W]); m_pending[c] = 1; end
      end
      case (m_state)
        0: if (m_sc == SC - 1) begin m_state = 1; m_ready = 1; m_cfgr = 1; end else m_sc++;
        1: if (acc) begin m_state = 2; m_cfgr = 0; end
        default: if (!any_pend) begin m_state = 1; m_cfgr = 1; end
      endcase
    end
    e = {m_ready, m_cfgr, m_co, m_ce};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Releases reset and checks the settle window and the DIV_INIT waveforms that follow it.
  task automatic test_settle_run(input string tag);
    obs_t e;
    int rise;
    bit [N-1:0] co_h[64], ce_h[64];
    rise = -1;
    rst  = 1'b0;
    for (int i = 1; i <= SC + 12; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL %s_sb cyc=%0d got=%h exp=%h", tag, i, obs, e); end
      if (ready === 1'b1 && rise < 0) rise = i;
      co_h[i] = clk_out; ce_h[i] = clk_en;
    end
    vecs++;
    if (rise != SC) begin errs++; $display("FAIL %s_ready_rise got=%0d exp=%0d", tag, rise, SC); end
    for (int i = 1; i <= SC + 12; i++) begin
      int p;
      bit [N-1:0] xo, xe;
      p  = i - SC - 1;
      xo = (i <= SC) ? '0 : {p % 8 < 4, p % 4 < 2, p % 2 < 1};
      xe = (i <= SC) ? '0 : {p % 8 == 7, p % 4 == 3, p % 2 == 1};
      vecs++;
      if (co_h[i] !== xo || ce_h[i] !== xe) begin
        errs++; $display("FAIL %s_wave cyc=%0d got=%b/%b exp=%b/%b", tag, i, co_h[i], ce_h[i], xo, xe);
      end
    end
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1; cfg_valid = 1'b0; div_cfg = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL reset_sb got=%h exp=%h", obs, e); end
    end
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_zero got=%h exp=0", obs); end
    test_settle_run("reset");
  endtask

  task automatic test_odd();
    obs_t e;
    int hi[N], en[N];
    div_cfg = {8'd5, 8'd3, 8'd7}; cfg_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(); cfg_valid = 1'b0;
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL odd_sb cyc=%0d got=%h exp=%h", i, obs, e); end
    end
    for (int c = 0; c < N; c++) begin hi[c] = 0; en[c] = 0; end
    for (int i = 0; i < 105; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL odd_sb2 cyc=%0d got=%h exp=%h", i, obs, e); end
      for (int c = 0; c < N; c++) begin hi[c] += int'(clk_out[c]); en[c] += int'(clk_en[c]); end
    end
    vecs++;
    if (hi[0] != 45 || hi[1] != 35 || hi[2] != 42 || en[0] != 15 || en[1] != 35 || en[2] != 21) begin
      errs++;
      $display("FAIL odd_duty got hi=%0d,%0d,%0d en=%0d,%0d,%0d exp hi=45,35,42 en=15,35,21",
               hi[0], hi[1], hi[2], en[0], en[1], en[2]);
    end
  endtask

  task automatic test_glitch();
    obs_t e;
    bit found;
    div_cfg = {8'd8, 8'd3, 8'd7}; cfg_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(); cfg_valid = 1'b0;
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL glitch_sb cyc=%0d got=%h exp=%h", i, obs, e); end
    end
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (m_ph[2] == 2 && m_cfgr) begin
        found = 1;
      end else begin
        tick();
        e = sb_q.pop_front(); vecs++;
        if (obs !== e) begin errs++; $display("FAIL glitch_wait got=%h exp=%h", obs, e); end
      end
    end
    vecs++;
    if (!found) begin errs++; $display("FAIL glitch_align got=none exp=cnt2"); end
    div_cfg = {8'd3, 8'd3, 8'd7}; cfg_valid = 1'b1;
    tick(); cfg_valid = 1'b0;
    e = sb_q.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL glitch_acc got=%h exp=%h", obs, e); end
    for (int k = 1; k <= 14; k++) begin
      bit xo, xe;
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL glitch_sb2 k=%0d got=%h exp=%h", k, obs, e); end
      xo = (k == 1) || (k >= 6 && (k - 6) % 3 == 0);
      xe = (k == 5) || (k >= 8 && (k - 8) % 3 == 0);
      vecs++;
      if (clk_out[2] !== xo || clk_en[2] !== xe) begin
        errs++; $display("FAIL glitch_ch2 k=%0d got=%b/%b exp=%b/%b", k, clk_out[2], clk_en[2], xo, xe);
      end
    end
  endtask

  task automatic test_special();
    obs_t e;
    int hi2;
    div_cfg = {8'd2, 8'd1, 8'd0}; cfg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); cfg_valid = 1'b0;
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL special_sb cyc=%0d got=%h exp=%h", i, obs, e); end
    end
    hi2 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL special_sb2 got=%h exp=%h", obs, e); end
      hi2 += int'(clk_out[2]);
      vecs++;
      if (clk_out[1:0] !== 2'b00 || clk_en[1:0] !== 2'b10) begin
        errs++; $display("FAIL special_const got=%b/%b exp=00/10", clk_out[1:0], clk_en[1:0]);
      end
    end
    vecs++;
    if (hi2 != 4) begin errs++; $display("FAIL special_ch2 got=%0d exp=4", hi2); end
    div_cfg = {8'd2, 8'd0, 8'd1}; cfg_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(); cfg_valid = 1'b0;
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL special_sb3 k=%0d got=%h exp=%h", k, obs, e); end
      if (k == 1 || k == 2) begin
        vecs++;
        if (clk_en[1:0] !== ((k == 1) ? 2'b10 : 2'b01)) begin
          errs++; $display("FAIL special_switch k=%0d got=%b exp=%b", k, clk_en[1:0], (k == 1) ? 2'b10 : 2'b01);
        end
      end
    end
  endtask

  task automatic test_handshake();
    obs_t e;
    int hi[N];
    rst = 1'b1; cfg_valid = 1'b1; div_cfg = {8'd4, 8'd2, 8'd6};
    tick();
    e = sb_q.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL hs_rst got=%h exp=%h", obs, e); end
    rst = 1'b0;
    for (int i = 1; i <= SC + 1; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL hs_settle cyc=%0d got=%h exp=%h", i, obs, e); end
      if (i >= SC - 1) begin
        vecs++;
        if (cfg_ready !== (i == SC)) begin
          errs++; $display("FAIL hs_ready cyc=%0d got=%b exp=%b", i, cfg_ready, i == SC);
        end
      end
    end
    div_cfg = {8'd3, 8'd3, 8'd3};
    for (int i = 0; i < 30; i++) begin
      if (i == 29) cfg_valid = 1'b0;
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL hs_drain cyc=%0d got=%h exp=%h", i, obs, e); end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL hs_idle cyc=%0d got=%h exp=%h", i, obs, e); end
    end
    for (int c = 0; c < N; c++) hi[c] = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL hs_b got=%h exp=%h", obs, e); end
      for (int c = 0; c < N; c++) hi[c] += int'(clk_out[c]);
    end
    vecs++;
    if (hi[0] != 3 || hi[1] != 3 || hi[2] != 3) begin
      errs++; $display("FAIL hs_second_cfg got=%0d,%0d,%0d exp=3,3,3", hi[0], hi[1], hi[2]);
    end
  endtask

  task automatic test_reset_mid_drain();
    obs_t e;
    div_cfg = {8'd7, 8'd7, 8'd7}; cfg_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); cfg_valid = 1'b0;
      e = sb_q.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL middrain_sb got=%h exp=%h", obs, e); end
    end
    vecs++;
    if (cfg_ready !== 1'b0) begin errs++; $display("FAIL middrain_state got=%b exp=0", cfg_ready); end
    rst = 1'b1;
    tick();
    e = sb_q.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL middrain_rst_sb got=%h exp=%h", obs, e); end
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL middrain_zero got=%h exp=0", obs); end
    test_settle_run("middrain");
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; div_cfg = '0;
    #1;
    test_reset();
    test_odd();
    test_glitch();
    test_special();
    test_handshake();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
